sig_comp: RTL



---
 rtl/sig_comp.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sig_comp.sv
// Parametrised SISR/MISR signature compactor with a run-length counter.
// Define SIG_CMP_EN to build the golden-signature comparator (pass/fail).
module sig_comp #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h1D,
    parameter int               LEN   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pdin,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam int CW = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] nxt;
    logic             last_cycle;
    logic             enter_done;

    assign din = mode ? pdin : {{(WIDTH-1){1'b0}}, si};

    // Galois LFSR step: the MSB is fed back into every tap stage.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign nxt[gi] = (POLY[gi] & sig_q[WIDTH-1]) ^ din[gi];
            end else begin : g_rest
                assign nxt[gi] = sig_q[gi-1] ^ (POLY[gi] & sig_q[WIDTH-1]) ^ din[gi];
            end
        end
    endgenerate

    assign last_cycle = (cnt_q == CW'(LEN - 1));
    assign enter_done = !start && (state_q == RUN) && en && last_cycle;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = RUN;
            sig_d   = seed;
            cnt_d   = '0;
        end else if (state_q == RUN && en) begin
            sig_d = nxt;
            cnt_d = cnt_q + CW'(1);
            if (last_cycle) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sig  = sig_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

`ifdef SIG_CMP_EN
    logic pass_q, pass_d;
    logic fail_q, fail_d;

    // The verdict is taken from the final signature as it is being written.
    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        if (start) begin
            pass_d = 1'b0;
            fail_d = 1'b0;
        end else if (enter_done) begin
            pass_d = (nxt == exp_sig);
            fail_d = (nxt != exp_sig);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
`else
    logic unused_cmp;
    assign unused_cmp = (^exp_sig) ^ enter_done;
    assign pass       = 1'b0;
    assign fail       = 1'b0;
`endif

endmodule
